// File: rtl/jk_drive_seq_pkg.sv
// Shared types for the J/K drive sequencer.
//   jk_op_t    : J/K operation, encoded as {j, k}
//   jk_state_t : sequencer FSM states
//   jk_cmd_t   : one queued command {op, rep}
package jk_pkg;

  localparam int unsigned JK_REP_W = 4;

  typedef enum logic [1:0] {
    OpHold   = 2'b00,
    OpReset  = 2'b01,
    OpSet    = 2'b10,
    OpToggle = 2'b11
  } jk_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDrain
  } jk_state_t;

  typedef struct packed {
    jk_op_t              op;
    logic [JK_REP_W-1:0] rep;
  } jk_cmd_t;

endpackage

// File: rtl/jk_drive_seq_if.sv
// Command handshake into the J/K drive sequencer.
//   cmd_valid : command present
//   cmd_op    : operation to drive
//   cmd_rep   : drive op for cmd_rep+1 cycles
//   cmd_ready : sequencer can accept a command
interface jk_drive_seq_if;
  import jk_pkg::*;

  logic                cmd_valid;
  jk_op_t              cmd_op;
  logic [JK_REP_W-1:0] cmd_rep;
  logic                cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_rep, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of jk_cmd_t.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and data (ignored when full)
//   pop, rdata   : read request (ignored when empty), head-of-queue data
//   full, empty  : occupancy flags
module jk_cmd_fifo
  import jk_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  jk_cmd_t wdata,
  input  logic    pop,
  output jk_cmd_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  jk_cmd_t     mem_q [DEPTH];
  logic        push_ok, pop_ok;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    rdata   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_drive_seq.sv
// Queues J/K commands, drives them onto a jk_ff for rep+1 cycles each, tracks the
// expected q and counts cycles where the returned q disagrees.
//   clk, rst : clock, synchronous active-high reset
//   cmd      : command handshake (slave side)
//   j, k     : registered drive to the flop
//   q_in     : q returned from the flop
//   busy     : queued work or FSM not idle
//   mismatch : one-cycle pulse, registered, after a failed compare
//   err_cnt  : saturating mismatch count
module jk_drive_seq
  import jk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_drive_seq_if.slave    cmd,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  jk_state_t           state_q, state_d;
  jk_op_t              op_q, op_d;
  logic [JK_REP_W-1:0] rem_q, rem_d;
  logic                exp_val_q, exp_val_d;
  logic                exp_known_q, exp_known_d;
  logic                chk_pend_q;
  logic                mismatch_q, mis_det;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic    push, pop, fifo_full, fifo_empty;
  jk_cmd_t wcmd, head;

  always_comb begin
    push          = cmd.cmd_valid && !fifo_full;
    cmd.cmd_ready = !fifo_full;
    wcmd.op       = cmd.cmd_op;
    wcmd.rep      = cmd.cmd_rep;
  end

  jk_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wcmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sequencer: op_q is HOLD whenever not driving, so j/k come straight from it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          op_d    = head.op;
          rem_d   = head.rep;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end else if (!fifo_empty) begin
          // Chain straight into the next command, no gap cycle.
          pop   = 1'b1;
          op_d  = head.op;
          rem_d = head.rep;
        end else begin
          op_d    = OpHold;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Expected flop state follows the op being driven this cycle.
  always_comb begin
    exp_val_d   = exp_val_q;
    exp_known_d = exp_known_q;
    if (state_q == StDrive) begin
      case (op_q)
        OpSet: begin
          exp_val_d   = 1'b1;
          exp_known_d = 1'b1;
        end
        OpReset: begin
          exp_val_d   = 1'b0;
          exp_known_d = 1'b1;
        end
        OpToggle: exp_val_d = ~exp_val_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    mis_det   = chk_pend_q && exp_known_q && (q_in != exp_val_q);
    err_cnt_d = err_cnt_q;
    if (mis_det && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpHold;
      rem_q       <= '0;
      exp_val_q   <= 1'b0;
      exp_known_q <= 1'b0;
      chk_pend_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      exp_val_q   <= exp_val_d;
      exp_known_q <= exp_known_d;
      chk_pend_q  <= (state_q == StDrive);
      mismatch_q  <= mis_det;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    j        = op_q[1];
    k        = op_q[0];
    busy     = !fifo_empty || (state_q != StIdle);
    mismatch = mismatch_q;
    err_cnt  = err_cnt_q;
  end

endmodule

// File: doc/jk_drive_seq.md
# jk_drive_seq

Command-driven stimulus and checking stage that sits directly upstream of the `jk_ff` flip-flop. It queues J/K operations, drives them onto the flop's `j`/`k` inputs for a programmable number of cycles, and models the expected `q`. It compares the flop's returned `q` against that model every cycle and counts mismatches. It replaces hand-timed J/K stimulus with a self-checking, back-to-back command stream.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `CNT_W`, 8: width of error counter.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_op` in 2: 00 HOLD (j0 k0), 01 RESET (j0 k1), 10 SET (j1 k0), 11 TOGGLE (j1 k1).
- `cmd_rep` in 4: drive `cmd_op` for `cmd_rep+1` cycles.
- `cmd_ready` out 1: FIFO not full.
- `j`, `k` out 1 each: registered drive to `jk_ff`.
- `q_in` in 1: `q` returned from `jk_ff`.
- `busy` out 1: FIFO non-empty or state ≠ IDLE.
- `mismatch` out 1: registered one-cycle error pulse.
- `err_cnt` out CNT_W: saturating mismatch count.

## Operation
- Push when `cmd_valid && cmd_ready`; `{op,rep}` stored in FIFO. `cmd_ready = !full`; no push when full even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: `j`=`k`=0. If the FIFO is non-empty, pop, load `j`/`k` from op, set `rem=rep`, and go to DRIVE.
  - DRIVE: hold `j`/`k`. If `rem≠0`, decrement. If `rem==0` and the FIFO is non-empty, pop and load the next op with no gap cycle. If `rem==0` and the FIFO is empty, set `j`=`k`=0 and go to DRAIN.
  - DRAIN: one cycle for the final check, then IDLE.
- Expected model (`exp_q`, `exp_known`) updates on every edge where DRIVE is active, using the currently driven op:
  - SET: `exp_q=1`, `exp_known=1`.
  - RESET: `exp_q=0`, `exp_known=1`.
  - TOGGLE: `exp_q` inverts, and the known flag is kept.
  - HOLD: no change.
  - `exp_known` is 0 out of reset because `jk_ff` has no reset. Only SET or RESET make it known.
- `chk_pend` is the registered value of (state==DRIVE). In any cycle with `chk_pend && exp_known && q_in≠exp_q`, `mismatch` is 1 on the next cycle and `err_cnt` increments, saturating at 2^CNT_W−1. When `exp_known`=0, no check is made.

## Timing
- Reset values: `j`=0, `k`=0, `cmd_ready`=1, `busy`=0, `mismatch`=0, `err_cnt`=0. FIFO is empty, state is IDLE, `exp_known`=0, `chk_pend`=0.
- Reset asserted mid-command discards the FIFO and the in-flight op. `j`/`k` read 0 in the first cycle after the reset edge.
- Latency from an accept edge E0 into an idle, empty block:
  - Pop at E1.
  - `j`/`k` valid from E1 for `rep+1` cycles.
  - `jk_ff` updates `q` at E2.
  - Compare in cycle E2–E3.
  - `mismatch` high in cycle E3–E4.
- Back-to-back commands produce contiguous drive with no HOLD gap between them.
- Push into an empty FIFO while IDLE is never popped in the same cycle; the minimum latency is one cycle.
- `busy` stays high through DRAIN, so it falls only after the last check cycle.

## Structure
- Package `jk_pkg`:
  - `jk_op_t` enum (HOLD/RESET/SET/TOGGLE with the encodings above).
  - `jk_state_t` enum (IDLE/DRIVE/DRAIN).
  - `JK_REP_W=4`.
- Sub-module `jk_cmd_fifo`: synchronous FIFO with DEPTH entries of `{jk_op_t, rep}`, `push/pop/full/empty`, and sync reset. Wrap-around is handled by pointer bits.
- Top level holds the FSM, the `rem` counter, the expected model and the checker.

## Test plan
- Reset, then SET rep=0 → `j`=1, `k`=0 for exactly 1 cycle. `q_in` follows to 1. `mismatch` stays 0, `err_cnt`=0, `busy` falls after DRAIN.
- SET rep=0, TOGGLE rep=3 pushed back-to-back → `j`=`k`=1 for 4 contiguous cycles directly after the SET cycle. `q` sequence is 1,0,1,0,1 with no mismatch.
- TOGGLE rep=2 issued first after reset → no checks while `exp_known`=0, so `err_cnt`=0 whatever `q_in` does.
- Push 5 commands with DEPTH=4 while the first is driving (rep=15) → `cmd_ready` falls when 4 entries are held. The fifth is accepted only after a pop, and all 5 are driven in order.
- Force `q_in`=0 after SET rep=2 → `mismatch` pulses 3 cycles and `err_cnt`=3. With `CNT_W`=2 and 5 errors, `err_cnt` saturates at 3.
- Assert `rst` during RESET rep=10 with 2 queued → next cycle `j`=`k`=0, FIFO empty, `busy`=0, and no queued command is ever driven.
